wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Two-master round-robin Wishbone arbiter sharing one slave port (e.g. the i2c or Iluminacion
//  controller between the LM32 data bus and a second DMA/poller master). Grants whole bus
//  cycles (cyc-to-cyc), muxes master signals onto the slave and routes ack back. A watchdog
//  ends stalled transfers with err.
// PARAMETERS
//  timeout_cycles  255  stb-high-without-ack cycles before err is raised (1..255)
//  tw              8    watchdog counter width; must hold timeout_cycles
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset
//  m_adr_i    in   64  {m1,m0} addresses
//  m_dat_i    in   64  {m1,m0} write data
//  m_sel_i    in   8   {m1,m0} byte selects
//  m_we_i     in   2   write enables, bit n = master n
//  m_cyc_i    in   2   cycle requests
//  m_stb_i    in   2   strobes
//  m_dat_o    out  32  read data, s_dat_i broadcast to both
//  m_ack_o    out  2   ack, only owner bit ever set
//  m_err_o    out  2   watchdog error, one-cycle pulse to owner
//  s_adr_o    out  32  slave address (owner's)
//  s_dat_o    out  32  slave write data
//  s_sel_o    out  4   slave byte selects
//  s_we_o     out  1   slave write enable
//  s_cyc_o    out  1   slave cycle
//  s_stb_o    out  1   slave strobe
//  s_dat_i    in   32  slave read data
//  s_ack_i    in   1   slave ack
//  grant_o    out  2   one-hot current owner, 00 when idle
// BEHAVIOUR
//  Reset: state IDLE, grant_o=00, last=1 (m0 wins first), s_cyc/stb/we=0, s_adr/dat/sel=0,
//   m_ack_o=m_err_o=00, watchdog=0. Reset asserted mid-transfer aborts immediately, no ack.
//  FSM IDLE/OWN/DRAIN, registered state+owner; slave-side outputs combinational from owner.
//  IDLE: one cyc -> OWN that master next cycle; both -> non-last master; s_cyc_o=0.
//   Latency: m_cyc_i rise at edge N -> s_cyc_o=1 after edge N+1.
//  OWN: s_* = owner's m_*; s_cyc_o=m_cyc_i[own]; m_ack_o[own]=s_ack_i&m_stb_i[own].
//   Owner holds across multiple stb beats while cyc stays high (no preemption).
//   Owner cyc low -> IDLE, last<=own; one dead cycle before any new grant.
//   Non-owner requests wait; never see ack/err.
//  Watchdog: clears when s_stb_o=0 or s_ack_i=1; else +1 per cycle. Reaching
//   timeout_cycles -> m_err_o[own]=1 for one cycle, s_cyc_o/s_stb_o forced 0, -> DRAIN.
//   Ack arriving the same cycle as timeout wins: ack delivered, no err.
//  DRAIN: slave outputs idle; wait owner cyc low -> IDLE, last<=own.
//  Widths: all muxes 32-bit, no arithmetic except watchdog (saturates, no wrap).
// STRUCTURE
//  Package wb_arb_pkg: state encodings (IDLE/OWN/DRAIN), WB address/data/sel widths.
//  Sub-module wb_arb_watchdog: counter, clear/enable in, expired pulse out.
//  Top: FSM, round-robin last pointer, output muxing.
// TESTING
//  Reset, m0 cyc+stb read, slave ack 2 cycles later, s_dat_i=32'hCAFE0001 -> m_ack_o=01,
//   m_dat_o=CAFE0001, grant_o=01, then 00 after cyc drop.
//  Both masters request same cycle twice in sequence -> grants 01 then 10 then 01, one idle
//   cycle between each.
//  m0 owns, holds cyc for 3 stb beats while m1 requests -> m1 granted only after m0 cyc low;
//   m_ack_o[1] stays 0 meanwhile.
//  timeout_cycles=16, slave never acks -> m_err_o[own] pulses at 16th stalled cycle,
//   s_cyc_o=0, DRAIN until owner drops cyc.
//  Ack on exactly the 16th stalled cycle -> ack delivered, no err, stays OWN.
//  rst low mid-write -> s_cyc_o=0, grant_o=00 asynchronously; after release m0 wins.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared encodings and Wishbone widths for the two-master round-robin arbiter.
package wb_arb_pkg;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall counter: counts stb-without-ack cycles, flags the cycle that reaches the limit.
module wb_arb_watchdog #(
    parameter int tw    = 8,
    parameter int limit = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [tw-1:0] LAST = tw'(limit - 1);
    localparam logic [tw-1:0] MAX  = '1;

    logic [tw-1:0] cnt;

    // cnt holds the number of stalled cycles already seen, so the limit-th
    // stalled cycle is the one where cnt == limit-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != MAX)
            cnt <= cnt + 1'b1;
    end

    assign expired = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter: whole-cycle grants, owner muxed onto the slave.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int timeout_cycles = 255,
    parameter int tw             = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*AW-1:0]   m_adr_i,
    input  logic [2*DW-1:0]   m_dat_i,
    input  logic [2*SW-1:0]   m_sel_i,
    input  logic [1:0]        m_we_i,
    input  logic [1:0]        m_cyc_i,
    input  logic [1:0]        m_stb_i,
    output logic [DW-1:0]     m_dat_o,
    output logic [1:0]        m_ack_o,
    output logic [1:0]        m_err_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [SW-1:0]     s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o
);

    arb_state_t state, state_n;
    logic       own, own_n;
    logic       last, last_n;
    logic       stall, expired;

    logic [1:0][AW-1:0] adr_v;
    logic [1:0][DW-1:0] dat_v;
    logic [1:0][SW-1:0] sel_v;

    assign adr_v   = m_adr_i;
    assign dat_v   = m_dat_i;
    assign sel_v   = m_sel_i;
    assign m_dat_o = s_dat_i;

    // raw owner strobe, taken before the timeout force so the watchdog has no loop
    assign stall = (state == OWN) & m_cyc_i[own] & m_stb_i[own];

    wb_arb_watchdog #(.tw(tw), .limit(timeout_cycles)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (s_ack_i | ~stall),
        .en      (stall),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            own   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            own   <= own_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        own_n   = own;
        last_n  = last;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = 2'b00;
        m_err_o = 2'b00;
        grant_o = 2'b00;
        unique case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_n = OWN;
                    // contention goes to whoever did not own the bus last
                    own_n   = (&m_cyc_i) ? ~last : m_cyc_i[1];
                end
            end
            OWN: begin
                grant_o      = own ? 2'b10 : 2'b01;
                s_adr_o      = adr_v[own];
                s_dat_o      = dat_v[own];
                s_sel_o      = sel_v[own];
                s_we_o       = m_we_i[own];
                s_cyc_o      = m_cyc_i[own] & ~expired;
                s_stb_o      = m_stb_i[own] & ~expired;
                m_ack_o[own] = s_ack_i & m_stb_i[own];
                m_err_o[own] = expired;
                if (expired) begin
                    state_n = DRAIN;
                end else if (!m_cyc_i[own]) begin
                    state_n = IDLE;
                    last_n  = own;
                end
            end
            DRAIN: begin
                grant_o = own ? 2'b10 : 2'b01;
                if (!m_cyc_i[own]) begin
                    state_n = IDLE;
                    last_n  = own;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Cycle-table bench for wb_rr_arbiter: rows queued as expectations, checked mid-cycle.
module tb_wb_rr_arbiter;

    localparam logic [31:0] A0 = 32'h1000_0010;
    localparam logic [31:0] A1 = 32'h2000_0020;
    localparam logic [31:0] D0 = 32'h0000_AAAA;
    localparam logic [31:0] D1 = 32'h0000_BBBB;
    localparam logic [3:0]  S0 = 4'h3;
    localparam logic [3:0]  S1 = 4'hC;
    localparam logic [31:0] RD = 32'hCAFE_0001;

    logic        clk, rst;
    logic [63:0] m_adr_i, m_dat_i;
    logic [7:0]  m_sel_i;
    logic [1:0]  m_we_i, m_cyc_i, m_stb_i;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    wb_rr_arbiter #(.timeout_cycles(16), .tw(8)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cyc, stb, we;
        logic       ack;
        logic [1:0] gnt;
        logic       scyc, sstb, swe;
        logic [1:0] src, mack, merr;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rowno  = 0;

    function automatic vec_t mk(logic [1:0] cyc, logic [1:0] stb, logic [1:0] we, logic ack,
                                logic [1:0] gnt, logic scyc, logic sstb, logic swe,
                                logic [1:0] src, logic [1:0] mack, logic [1:0] merr);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack;
        v.gnt = gnt; v.scyc = scyc; v.sstb = sstb; v.swe = swe;
        v.src = src; v.mack = mack; v.merr = merr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", nm, rowno, act, exp);
        end
    endtask

    task automatic compare_row();
        vec_t e;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard row %0d: got empty queue want entry", rowno);
            return;
        end
        e  = exp_q.pop_front();
        ea = (e.src == 2'b01) ? A0 : (e.src == 2'b10) ? A1 : 32'h0;
        ed = (e.src == 2'b01) ? D0 : (e.src == 2'b10) ? D1 : 32'h0;
        es = (e.src == 2'b01) ? S0 : (e.src == 2'b10) ? S1 : 4'h0;
        chk("grant",   {30'h0, grant_o}, {30'h0, e.gnt});
        chk("s_cyc",   {31'h0, s_cyc_o}, {31'h0, e.scyc});
        chk("s_stb",   {31'h0, s_stb_o}, {31'h0, e.sstb});
        chk("s_we",    {31'h0, s_we_o},  {31'h0, e.swe});
        chk("m_ack",   {30'h0, m_ack_o}, {30'h0, e.mack});
        chk("m_err",   {30'h0, m_err_o}, {30'h0, e.merr});
        chk("s_adr",   s_adr_o, ea);
        chk("s_dat",   s_dat_o, ed);
        chk("s_sel",   {28'h0, s_sel_o}, {28'h0, es});
        chk("m_dat",   m_dat_o, RD);
    endtask

    // one bus cycle: drive after the edge, compare on the falling edge
    task automatic step(input vec_t v);
        m_cyc_i = v.cyc; m_stb_i = v.stb; m_we_i = v.we; s_ack_i = v.ack;
        exp_q.push_back(v);
        @(negedge clk);
        compare_row();
        rowno++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00; s_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        m_adr_i = {A1, A0}; m_dat_i = {D1, D0}; m_sel_i = {S1, S0};
        s_dat_i = RD;
        rst = 1'b0;
        m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b11; s_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {30'h0, grant_o}, 32'h0);
        chk("rst_scyc",  {31'h0, s_cyc_o}, 32'h0);
        chk("rst_sadr",  s_adr_o, 32'h0);
        chk("rst_mack",  {30'h0, m_ack_o}, 32'h0);
        do_reset();

        // m0 read, ack two cycles after grant
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1, 1, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1, 1, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 1, 1, 0, 2'b01, 2'b01, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        run_tbl();
        do_reset();

        // simultaneous requests alternate 01 -> 10 -> 01 with a dead cycle between
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1, 1, 0, 2'b01, 2'b01, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b10, 1, 1, 0, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b10, 0, 0, 0, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1, 1, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00));

        // m0 holds for three beats while m1 waits
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1, 1, 0, 2'b01, 2'b01, 2'b00));
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, 1'b0, 2'b01, 1, 0, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1, 1, 0, 2'b01, 2'b01, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1'b1, 2'b01, 1, 1, 0, 2'b01, 2'b01, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b00, 1'b1, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b00, 1'b1, 2'b10, 1, 1, 0, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 0, 0, 0, 2'b10, 2'b00, 2'b00));
        run_tbl();

        // m0 stalls: err on the 16th stalled cycle, then drain until cyc drops
        step(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        for (int k = 1; k <= 15; k++)
            step(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1, 1, 0, 2'b01, 2'b00, 2'b00));
        step(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b01));
        for (int k = 0; k < 2; k++)
            step(mk(2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        step(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        step(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));

        // m1 acked exactly on the 16th stalled cycle: ack wins, bus stays owned
        step(mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        for (int k = 1; k <= 15; k++)
            step(mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1, 1, 0, 2'b10, 2'b00, 2'b00));
        step(mk(2'b10, 2'b10, 2'b00, 1'b1, 2'b10, 1, 1, 0, 2'b10, 2'b10, 2'b00));
        step(mk(2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1, 1, 0, 2'b10, 2'b00, 2'b00));
        step(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 0, 0, 0, 2'b10, 2'b00, 2'b00));
        step(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));

        // reset dropped in the middle of an m0 write
        step(mk(2'b01, 2'b01, 2'b01, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        step(mk(2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1, 1, 1, 2'b01, 2'b00, 2'b00));
        m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b01;
        #2 rst = 1'b0;
        #1;
        chk("arst_grant", {30'h0, grant_o}, 32'h0);
        chk("arst_scyc",  {31'h0, s_cyc_o}, 32'h0);
        chk("arst_mack",  {30'h0, m_ack_o}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(mk(2'b11, 2'b11, 2'b01, 1'b0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        step(mk(2'b11, 2'b11, 2'b01, 1'b0, 2'b01, 1, 1, 1, 2'b01, 2'b00, 2'b00));
        step(mk(2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
